bitwise_seq_unit: RTL and testbench
===================================

# bitwise_seq_unit

Parametrised, sequential successor to the team's fixed 16-bit bitwise gates. It performs AND, OR, XOR or NOT over a WIDTH-bit operand pair, SLICE bits per clock, behind a valid/ready handshake. The result is held until the consumer takes it. It sits between the register file and the ALU result mux, where area matters more than single-cycle latency.

## Interface
- WIDTH, 16, operand/result width in bits; must be at least 1.
- SLICE, 4, bits processed per RUN cycle. Must divide WIDTH exactly; otherwise elaboration fails via a generate-time error.
- NSLICE (localparam), WIDTH/SLICE, RUN cycles per operation.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair and op are valid.
- in_ready  output  1  unit can accept a new operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored for NOT).
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOT a.
- out_valid  output  1  result is valid and held.
- out_ready  input  1  consumer takes the result.
- out  output  WIDTH  result word.
- zero  output  1  result is all zeros; meaningful only while out_valid=1.

## Operation
- FSM states:
  - IDLE: in_ready=1. in_valid=1 latches a, b and op, clears the slice index to 0 and moves to RUN.
  - RUN: each cycle computes result[idx*SLICE +: SLICE] from the latched operands and op, then increments idx. After slice NSLICE-1 it moves to DONE.
  - DONE: out_valid=1 and out/zero are held stable. out_ready=1 returns to IDLE.
- in_ready=1 only in IDLE. There is no overlap: a new operation is not accepted in the DONE→IDLE transition cycle.
- Operands and op are sampled only at acceptance. Changes to a, b, op or in_valid during RUN or DONE have no effect.
- out_ready is ignored outside DONE.
- The result register holds the last result after returning to IDLE. out keeps that value until the next operation overwrites it slice by slice. Consumers must qualify out with out_valid.
- zero is registered and loaded on the RUN→DONE transition from the complete result, including the slice written in that same cycle.
- NOT ignores b entirely. The result is the bitwise complement of a across all WIDTH bits.
- WIDTH==SLICE is legal: NSLICE=1, giving one RUN cycle.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out=0, zero=0, slice index 0, latched operands 0.
- Reset is asynchronous. Asserting it in any state, including mid-RUN, aborts the operation immediately; no partial result is preserved. First acceptance is possible on the first rising edge after reset deasserts.
- Latency: operation accepted at edge T, RUN occupies edges T+1..T+NSLICE, and out_valid rises after edge T+NSLICE. For defaults, out_valid goes high 4 cycles after acceptance.
- DONE exits on the first edge with out_ready=1. in_ready rises after that edge.
- Minimum issue interval: NSLICE+2 cycles when out_ready is held at 1.
- Slices are written LSB-first. Intermediate values of out during RUN are undefined to the consumer.

## Test plan
- Reset mid-RUN:
  - Stimulus: accept a=16'hFFFF, b=0, op=01, then assert reset after 2 RUN cycles.
  - Required response: immediately out_valid=0, out=0, in_ready=1.
  - Then after release: a fresh op=00 with a=16'h00FF, b=16'h0F0F gives out=16'h000F after 4 cycles.
- OR with held output, defaults:
  - Stimulus: a=16'hA0A0, b=16'h0505, op=01, out_ready=0.
  - Required response: out_valid rises exactly 4 cycles after acceptance, out=16'hA5A5, zero=0. out is held for 10 stalled cycles.
  - Raising out_ready returns to IDLE next edge.
- XOR to zero, and input stability:
  - Stimulus: a=b=16'h1234, op=10, and change a to 16'hFFFF during RUN.
  - Required response: out=16'h0000, zero=1.
- NOT, ignored b, back-to-back throughput:
  - Stimulus: a=16'h00F0, b=16'hFFFF, op=11.
  - Required response: out=16'hFF0F.
  - With in_valid and out_ready held high, operations complete every 6 cycles.
- Parameter sweep:
  - Stimulus: WIDTH=16/SLICE=16 and WIDTH=32/SLICE=1, random a, b, op.
  - Required response: latency is 1 and 32 cycles respectively, and out matches the bitwise reference model on every operation.
- Handshake hygiene:
  - Stimulus: in_valid pulsed during RUN/DONE, and out_ready pulsed in IDLE/RUN.
  - Required response: no extra acceptance and no spurious state change. in_ready is 0 in all non-IDLE cycles.

Source files
------------

// File: rtl/bitwise_seq_unit.sv
// Slice-serial bitwise unit: AND/OR/XOR/NOT over a WIDTH-bit operand pair,
// SLICE bits per cycle, with a valid/ready handshake on both sides.
module bitwise_seq_unit #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  generate
    if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_param_check
      $error("bitwise_seq_unit: SLICE must be >= 1 and divide WIDTH (>= 1) exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic [SLICE-1:0] a_sl, b_sl;

  function automatic logic [SLICE-1:0] slice_op(input logic [SLICE-1:0] sa,
                                                input logic [SLICE-1:0] sb,
                                                input logic [1:0]       sop);
    logic [SLICE-1:0] r;
    unique case (sop)
      2'b00:   r = sa & sb;
      2'b01:   r = sa | sb;
      2'b10:   r = sa ^ sb;
      default: r = ~sa;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    a_sl    = '0;
    b_sl    = '0;

    // Only one SLICE-wide gate exists; operands are muxed down to it by idx.
    for (int s = 0; s < NSLICE; s++) begin
      if (idx_q == IDX_W'(s)) begin
        a_sl = a_q[s*SLICE +: SLICE];
        b_sl = b_q[s*SLICE +: SLICE];
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int s = 0; s < NSLICE; s++) begin
          if (idx_q == IDX_W'(s)) begin
            res_d[s*SLICE +: SLICE] = slice_op(a_sl, b_sl, op_q);
          end
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // zero must see the slice being written this cycle, hence res_d.
          zero_d  = (res_d == '0);
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = res_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_bitwise_seq_unit.sv
// Scoreboard bench for bitwise_seq_unit: directed handshake cases on the
// default 16/4 build plus latency and random streams on 16/16 and 32/1 builds.
module tb_bitwise_seq_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  in_valid_v;
  logic [2:0]  out_ready_v;
  logic [31:0] a_s [3];
  logic [31:0] b_s [3];
  logic [1:0]  op_s [3];
  wire  [2:0]  in_ready_v;
  wire  [2:0]  out_valid_v;
  wire  [2:0]  zero_v;
  logic [15:0] out0, out1;
  logic [31:0] out2;
  logic [31:0] out_s [3];

  assign out_s[0] = {16'h0, out0};
  assign out_s[1] = {16'h0, out1};
  assign out_s[2] = out2;

  int lat_exp [3] = '{4, 1, 32};
  int wid     [3] = '{16, 16, 32};

  int n_assert = 0;
  int n_fail   = 0;
  logic [32:0] sb [$];

  bitwise_seq_unit #(.WIDTH(16), .SLICE(4)) u_dut16x4 (
    .clk(clk), .reset(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_s[0][15:0]), .b(b_s[0][15:0]), .op(op_s[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .out(out0), .zero(zero_v[0]));

  bitwise_seq_unit #(.WIDTH(16), .SLICE(16)) u_dut16x16 (
    .clk(clk), .reset(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_s[1][15:0]), .b(b_s[1][15:0]), .op(op_s[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .out(out1), .zero(zero_v[1]));

  bitwise_seq_unit #(.WIDTH(32), .SLICE(1)) u_dut32x1 (
    .clk(clk), .reset(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_s[2]), .b(b_s[2]), .op(op_s[2]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .out(out2), .zero(zero_v[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                         input logic [1:0] o, input int w);
    logic [31:0] r;
    logic [31:0] m;
    case (o)
      2'b00:   r = x & y;
      2'b01:   r = x | y;
      2'b10:   r = x ^ y;
      default: r = ~x;
    endcase
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return r & m;
  endfunction

  task automatic push_exp(input int k, input logic [31:0] x, input logic [31:0] y,
                          input logic [1:0] o);
    logic [31:0] r;
    r = ref_op(x, y, o, wid[k]);
    sb.push_back({(r == 32'd0), r});
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input int k, input logic [31:0] x, input logic [31:0] y,
                       input logic [1:0] o);
    in_valid_v[k] = 1'b1;
    a_s[k] = x;
    b_s[k] = y;
    op_s[k] = o;
    check_eq("issue_in_ready", in_ready_v[k], 1);
    push_exp(k, x, y, o);
    @(negedge clk);
    in_valid_v[k] = 1'b0;
  endtask

  task automatic wait_result(input int k, input int exp_lat, input string tag);
    int cnt;
    logic [32:0] e;
    cnt = 0;
    while (!out_valid_v[k] && cnt < exp_lat + 8) begin
      check_eq({tag, "_in_ready_busy"}, in_ready_v[k], 0);
      @(negedge clk);
      cnt++;
    end
    check_eq({tag, "_latency"}, cnt, exp_lat);
    if (out_valid_v[k]) begin
      check_eq({tag, "_in_ready_done"}, in_ready_v[k], 0);
      check_eq({tag, "_sb_depth"}, sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq({tag, "_out"}, out_s[k], e[31:0]);
        check_eq({tag, "_zero"}, zero_v[k], e[32]);
      end
    end
  endtask

  task automatic release_out(input int k, input string tag);
    out_ready_v[k] = 1'b1;
    @(negedge clk);
    out_ready_v[k] = 1'b0;
    check_eq({tag, "_rel_out_valid"}, out_valid_v[k], 0);
    check_eq({tag, "_rel_in_ready"}, in_ready_v[k], 1);
  endtask

  task automatic stream(input int k, input int n, input string tag);
    int done_n, issued, cyc, last;
    logic [31:0] x, y;
    logic [1:0] o;
    logic [32:0] e;
    done_n = 0; issued = 0; cyc = 0; last = -1;
    out_ready_v[k] = 1'b1;
    while (done_n < n && cyc < n * (lat_exp[k] + 2) + 20) begin
      if (out_valid_v[k]) begin
        check_eq({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_eq({tag, "_out"}, out_s[k], e[31:0]);
          check_eq({tag, "_zero"}, zero_v[k], e[32]);
        end
        if (last >= 0) check_eq({tag, "_interval"}, cyc - last, lat_exp[k] + 2);
        last = cyc;
        done_n++;
      end
      if (issued < n) begin
        x = $urandom;
        y = $urandom;
        o = 2'($urandom_range(0, 3));
        in_valid_v[k] = 1'b1;
        a_s[k] = x;
        b_s[k] = y;
        op_s[k] = o;
        if (in_ready_v[k]) begin
          push_exp(k, x, y, o);
          issued++;
        end
      end else begin
        in_valid_v[k] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_completed"}, done_n, n);
    in_valid_v[k] = 1'b0;
    out_ready_v[k] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    in_valid_v = '0;
    out_ready_v = '0;
    for (int k = 0; k < 3; k++) begin
      a_s[k] = '0;
      b_s[k] = '0;
      op_s[k] = '0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_in_ready", in_ready_v[k], 1);
      check_eq("rst_out_valid", out_valid_v[k], 0);
      check_eq("rst_out", out_s[k], 0);
      check_eq("rst_zero", zero_v[k], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Reset asserted after two RUN cycles aborts the operation.
    issue(0, 32'hFFFF, 32'h0, 2'b01);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", out_valid_v[0], 0);
    check_eq("midrst_out", out_s[0], 0);
    check_eq("midrst_in_ready", in_ready_v[0], 1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(0, 32'h00FF, 32'h0F0F, 2'b00);
    wait_result(0, 4, "and_after_rst");
    release_out(0, "and_after_rst");

    // OR with the consumer stalling for 10 cycles.
    issue(0, 32'hA0A0, 32'h0505, 2'b01);
    wait_result(0, 4, "or_hold");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("or_hold_out", out_s[0], 32'hA5A5);
      check_eq("or_hold_valid", out_valid_v[0], 1);
      check_eq("or_hold_in_ready", in_ready_v[0], 0);
    end
    release_out(0, "or_hold");
    check_eq("or_idle_out_kept", out_s[0], 32'hA5A5);

    // XOR to zero while inputs and in_valid wiggle during RUN and DONE.
    issue(0, 32'h1234, 32'h1234, 2'b10);
    a_s[0] = 32'hFFFF;
    op_s[0] = 2'b11;
    in_valid_v[0] = 1'b1;
    wait_result(0, 4, "xor_zero");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("xor_done_valid", out_valid_v[0], 1);
      check_eq("xor_done_in_ready", in_ready_v[0], 0);
      check_eq("xor_done_out", out_s[0], 32'h0);
      check_eq("xor_done_zero", zero_v[0], 1);
    end
    in_valid_v[0] = 1'b0;
    release_out(0, "xor_zero");
    repeat (3) @(negedge clk);
    check_eq("xor_no_extra_accept", in_ready_v[0], 1);
    check_eq("xor_no_extra_valid", out_valid_v[0], 0);

    // out_ready pulsed in IDLE and RUN must not move the FSM.
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
    check_eq("idle_oready_in_ready", in_ready_v[0], 1);
    check_eq("idle_oready_valid", out_valid_v[0], 0);
    issue(0, 32'h00F0, 32'hFFFF, 2'b11);
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
    wait_result(0, 3, "not_a");
    release_out(0, "not_a");

    stream(0, 8, "b2b_16x4");

    // Parameter sweep: single-slice and single-bit builds.
    issue(1, 32'hC3C3, 32'h0FF0, 2'b10);
    wait_result(1, 1, "lat_16x16");
    release_out(1, "lat_16x16");
    stream(1, 12, "rand_16x16");

    issue(2, 32'hDEAD_BEEF, 32'h1234_5678, 2'b11);
    wait_result(2, 32, "lat_32x1");
    release_out(2, "lat_32x1");
    stream(2, 6, "rand_32x1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
